jt7759_rom_arb: RTL and testbench

JT7759_ROM_ARB -- requirements
Module: jt7759_rom_arb

---
 rtl/jt7759_rom_slot.sv | 51 +++++
 rtl/jt7759_rom_arb.sv | 122 ++++++++++++
 tb/tb_jt7759_rom_arb.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/jt7759_rom_slot.sv
// One-entry read cache for a jt7759 ROM channel: data latch, address tag, valid bit, registered ok.
// ok follows cs/addr by one edge; fills come only from the arbiter, and the slot never stalls.
module jt7759_rom_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [16:0] addr,
  input  logic        fill,
  input  logic [16:0] fill_tag,
  input  logic [7:0]  fill_data,
  output logic [7:0]  data,
  output logic        ok,
  output logic        hit
);

  logic [7:0]  data_q, data_d;
  logic [16:0] tag_q, tag_d;
  logic        valid_q, valid_d;
  logic        ok_q, ok_d;

  always_comb begin
    hit     = valid_q && (tag_q == addr);
    ok_d    = cs && hit;
    data_d  = data_q;
    tag_d   = tag_q;
    valid_d = valid_q;
    if (fill) begin
      data_d  = fill_data;
      tag_d   = fill_tag;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= 8'h00;
      tag_q   <= 17'h00000;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
    end else begin
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
    end
  end

  assign data = data_q;
  assign ok   = ok_q;

endmodule

// File: rtl/jt7759_rom_arb.sv
// Shares one downstream ROM port between two jt7759 channels, each fronted by a one-byte slot.
// Hit: 1 cycle to ok; miss: downstream latency + 2; requests hold until ok, rom_cs drops >=1 cycle between accesses.
module jt7759_rom_arb #(
  parameter logic [17:0] OFFSET0 = 18'h00000,
  parameter logic [17:0] OFFSET1 = 18'h20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ch0_cs,
  input  logic [16:0] ch0_addr,
  output logic [7:0]  ch0_data,
  output logic        ch0_ok,
  input  logic        ch1_cs,
  input  logic [16:0] ch1_addr,
  output logic [7:0]  ch1_data,
  output logic        ch1_ok,
  output logic        rom_cs,
  output logic [17:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        rom_cs_q, rom_cs_d;
  logic [17:0] rom_addr_q, rom_addr_d;
  logic        ptr_q, ptr_d;
  logic [16:0] snap_q, snap_d;

  logic hit0, hit1, pend0, pend1, grant0, grant1, fill0, fill1;

  jt7759_rom_slot u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .cs        (ch0_cs),
    .addr      (ch0_addr),
    .fill      (fill0),
    .fill_tag  (snap_q),
    .fill_data (rom_data),
    .data      (ch0_data),
    .ok        (ch0_ok),
    .hit       (hit0)
  );

  jt7759_rom_slot u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .cs        (ch1_cs),
    .addr      (ch1_addr),
    .fill      (fill1),
    .fill_tag  (snap_q),
    .fill_data (rom_data),
    .data      (ch1_data),
    .ok        (ch1_ok),
    .hit       (hit1)
  );

  // rom_ok only counts while our own request is out; stale answers after reset are dropped
  assign fill0 = (state_q == ST_GNT0) && rom_cs_q && rom_ok;
  assign fill1 = (state_q == ST_GNT1) && rom_cs_q && rom_ok;

  always_comb begin
    pend0      = ch0_cs && !hit0;
    pend1      = ch1_cs && !hit1;
    grant0     = pend0 && (!pend1 || !ptr_q);
    grant1     = pend1 && (!pend0 ||  ptr_q);
    state_d    = state_q;
    rom_cs_d   = rom_cs_q;
    rom_addr_d = rom_addr_q;
    ptr_d      = ptr_q;
    snap_d     = snap_q;
    case (state_q)
      ST_IDLE: begin
        if (pend0 && pend1) ptr_d = grant0;
        if (grant0) begin
          state_d    = ST_GNT0;
          rom_cs_d   = 1'b1;
          rom_addr_d = {1'b0, ch0_addr} + OFFSET0;
          snap_d     = ch0_addr;
        end else if (grant1) begin
          state_d    = ST_GNT1;
          rom_cs_d   = 1'b1;
          rom_addr_d = {1'b0, ch1_addr} + OFFSET1;
          snap_d     = ch1_addr;
        end
      end
      ST_GNT0, ST_GNT1: begin
        if (rom_cs_q && rom_ok) begin
          state_d  = ST_GAP;
          rom_cs_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rom_cs_q   <= 1'b0;
      rom_addr_q <= 18'h00000;
      ptr_q      <= 1'b0;
      snap_q     <= 17'h00000;
    end else begin
      state_q    <= state_d;
      rom_cs_q   <= rom_cs_d;
      rom_addr_q <= rom_addr_d;
      ptr_q      <= ptr_d;
      snap_q     <= snap_d;
    end
  end

  assign rom_cs   = rom_cs_q;
  assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_jt7759_rom_arb.sv
// Directed bench for jt7759_rom_arb: miss, hit, contention, abandon, reset mid-op and offset wrap.
module tb_jt7759_rom_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ch0_cs, ch1_cs;
  logic [16:0] ch0_addr, ch1_addr;
  logic [7:0]  ch0_data, ch1_data;
  logic        ch0_ok, ch1_ok;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;

  logic [7:0]  w_ch0_data, w_ch1_data;
  logic        w_ch0_ok, w_ch1_ok, w_rom_cs;
  logic [17:0] w_rom_addr;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  jt7759_rom_arb dut (
    .clk(clk), .rst(rst),
    .ch0_cs(ch0_cs), .ch0_addr(ch0_addr), .ch0_data(ch0_data), .ch0_ok(ch0_ok),
    .ch1_cs(ch1_cs), .ch1_addr(ch1_addr), .ch1_data(ch1_data), .ch1_ok(ch1_ok),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  // Same stimulus, channel 1 base placed at the top of the space to exercise wrap-around
  jt7759_rom_arb #(.OFFSET0(18'h00000), .OFFSET1(18'h3FFFF)) dut_w (
    .clk(clk), .rst(rst),
    .ch0_cs(ch0_cs), .ch0_addr(ch0_addr), .ch0_data(w_ch0_data), .ch0_ok(w_ch0_ok),
    .ch1_cs(ch1_cs), .ch1_addr(ch1_addr), .ch1_data(w_ch1_data), .ch1_ok(w_ch1_ok),
    .rom_cs(w_rom_cs), .rom_addr(w_rom_addr), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ch0_cs = 1'b0; ch1_cs = 1'b0; rom_ok = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    ch0_addr = '0; ch1_addr = '0; rom_data = '0;
    do_reset();

    // Reset state
    check("rst_rom_cs",   rom_cs,   0);
    check("rst_rom_addr", rom_addr, 0);
    check("rst_ch0_ok",   ch0_ok,   0);
    check("rst_ch1_ok",   ch1_ok,   0);
    check("rst_ch0_data", ch0_data, 0);
    check("rst_ch1_data", ch1_data, 0);

    // Single miss, downstream answers 3 cycles after rom_cs
    ch0_cs = 1'b1; ch0_addr = 17'h00123;
    tick();
    check("miss_rom_cs",   rom_cs,   1);
    check("miss_rom_addr", rom_addr, 18'h00123);
    check("miss_ok_early", ch0_ok,   0);
    tick();
    tick();
    check("miss_cs_held",   rom_cs,   1);
    check("miss_addr_held", rom_addr, 18'h00123);
    rom_ok = 1'b1; rom_data = 8'hA5;
    tick();
    rom_ok = 1'b0;
    check("miss_cs_drop", rom_cs,   0);
    check("miss_data",    ch0_data, 8'hA5);
    check("miss_ok_lat4", ch0_ok,   0);
    tick();
    check("miss_ok_lat5", ch0_ok,  1);
    check("miss_gap",     rom_cs,  0);
    tick();
    check("miss_ok_hold", ch0_ok,  1);
    check("miss_no_req",  rom_cs,  0);

    // Hit after a one-cycle cs drop
    ch0_cs = 1'b0;
    tick();
    check("hit_ok_fall", ch0_ok, 0);
    ch0_cs = 1'b1; ch0_addr = 17'h00123;
    tick();
    check("hit_ok",      ch0_ok,   1);
    check("hit_no_rom",  rom_cs,   0);
    check("hit_data",    ch0_data, 8'hA5);
    tick();
    check("hit_no_rom2", rom_cs,   0);
    ch0_cs = 1'b0;

    // Contention: both channels miss on the same cycle
    do_reset();
    ch0_cs = 1'b1; ch0_addr = 17'h00010;
    ch1_cs = 1'b1; ch1_addr = 17'h00010;
    tick();
    check("cont_first_cs",   rom_cs,   1);
    check("cont_first_addr", rom_addr, 18'h00010);
    rom_ok = 1'b1; rom_data = 8'h11;
    tick();
    rom_ok = 1'b0;
    check("cont_gap_cs", rom_cs, 0);
    tick();
    check("cont_ch0_ok", ch0_ok, 1);
    check("cont_idle_cs", rom_cs, 0);
    tick();
    check("cont_second_cs",   rom_cs,   1);
    check("cont_second_addr", rom_addr, 18'h20010);
    rom_ok = 1'b1; rom_data = 8'h22;
    tick();
    rom_ok = 1'b0;
    tick();
    check("cont_ch1_ok",   ch1_ok,   1);
    check("cont_ch1_data", ch1_data, 8'h22);
    check("cont_ch0_keep", ch0_data, 8'h11);
    // Second collision: pointer now favours channel 1
    ch0_addr = 17'h00020; ch1_addr = 17'h00020;
    tick();
    check("coll2_first_addr", rom_addr, 18'h20020);
    check("coll2_ch0_ok",     ch0_ok,   0);
    check("coll2_ch1_ok",     ch1_ok,   0);
    rom_ok = 1'b1; rom_data = 8'h33;
    tick();
    rom_ok = 1'b0;
    tick();
    tick();
    check("coll2_second_addr", rom_addr, 18'h00020);
    check("coll2_second_cs",   rom_cs,   1);
    rom_ok = 1'b1; rom_data = 8'h44;
    tick();
    rom_ok = 1'b0;
    tick();
    check("coll2_ch0_ok",   ch0_ok,   1);
    check("coll2_ch0_data", ch0_data, 8'h44);
    check("coll2_ch1_data", ch1_data, 8'h33);

    // Abandon: ch1 moves its address while its access is in flight
    do_reset();
    ch1_cs = 1'b1; ch1_addr = 17'h00050;
    tick();
    check("abn_addr", rom_addr, 18'h20050);
    ch1_addr = 17'h00051;
    tick();
    check("abn_cs_held",   rom_cs,   1);
    check("abn_addr_held", rom_addr, 18'h20050);
    rom_ok = 1'b1; rom_data = 8'h55;
    tick();
    rom_ok = 1'b0;
    check("abn_fill_data", ch1_data, 8'h55);
    check("abn_ok0",       ch1_ok,   0);
    tick();
    check("abn_ok1", ch1_ok, 0);
    tick();
    check("abn_regrant_cs",   rom_cs,   1);
    check("abn_regrant_addr", rom_addr, 18'h20051);
    check("abn_ok2",          ch1_ok,   0);
    rom_ok = 1'b1; rom_data = 8'h56;
    tick();
    rom_ok = 1'b0;
    tick();
    check("abn_new_ok",   ch1_ok,   1);
    check("abn_new_data", ch1_data, 8'h56);
    ch1_cs = 1'b0;

    // Reset in the middle of an access, late rom_ok must be ignored
    do_reset();
    ch0_cs = 1'b1; ch0_addr = 17'h00070;
    tick();
    check("rmo_cs_before", rom_cs, 1);
    rst = 1'b1; ch0_cs = 1'b0;
    tick();
    rst = 1'b0;
    check("rmo_cs_drop", rom_cs,   0);
    check("rmo_addr",    rom_addr, 0);
    tick();
    rom_ok = 1'b1; rom_data = 8'hFF;
    tick();
    rom_ok = 1'b0;
    check("rmo_no_fill0", ch0_data, 0);
    check("rmo_no_fill1", ch1_data, 0);
    check("rmo_ok0",      ch0_ok,   0);
    check("rmo_ok1",      ch1_ok,   0);
    check("rmo_cs_idle",  rom_cs,   0);
    ch0_cs = 1'b1;
    tick();
    check("rmo_still_miss_ok", ch0_ok, 0);
    check("rmo_regrant",       rom_cs, 1);
    rom_ok = 1'b1;
    tick();
    rom_ok = 1'b0;
    ch0_cs = 1'b0;
    tick();

    // Offset wrap modulo 2^18
    do_reset();
    ch1_cs = 1'b1; ch1_addr = 17'h00002;
    tick();
    check("wrap_cs",      w_rom_cs,   1);
    check("wrap_addr",    w_rom_addr, 18'h00001);
    check("nowrap_addr",  rom_addr,   18'h20002);
    rom_ok = 1'b1; rom_data = 8'h77;
    tick();
    rom_ok = 1'b0;
    tick();
    check("wrap_ok",   w_ch1_ok,   1);
    check("wrap_data", w_ch1_data, 8'h77);
    ch1_cs = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
